// File: rtl/mem_issue_queue_pkg.sv
// Shared definitions for the memory issue queue: physical register tag
// width, memory-op opcode encodings and the per-entry payload record.
package mem_issue_queue_pkg;

  localparam int PR_ADDR_W = 6;

  // Bit 0 of the opcode distinguishes stores (1) from loads (0).
  localparam logic [3:0] OP_LB = 4'h0;
  localparam logic [3:0] OP_SB = 4'h1;
  localparam logic [3:0] OP_LW = 4'h2;
  localparam logic [3:0] OP_SW = 4'h3;

  // Fields that are written at enqueue and never change while queued.
  typedef struct packed {
    logic [3:0]           opcode;
    logic [4:0]           rob_entry;
    logic [15:0]          base_val;
    logic [3:0]           imm;
    logic [PR_ADDR_W-1:0] dest_reg;
    logic [3:0]           dest_arch_regs;
  } iq_payload_t;

endpackage

// File: rtl/mem_iq_operand.sv
// One source operand of a queue entry: holds its tag, ready flag and value,
// and snoops both writeback ports. Port 0 wins when both ports hit.
module mem_iq_operand
  import mem_issue_queue_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 active,
  input  logic [PR_ADDR_W-1:0] in_tag,
  input  logic                 in_rdy,
  input  logic [W-1:0]         in_val,
  input  logic                 wb0_valid,
  input  logic [PR_ADDR_W-1:0] wb0_tag,
  input  logic [W-1:0]         wb0_data,
  input  logic                 wb1_valid,
  input  logic [PR_ADDR_W-1:0] wb1_tag,
  input  logic [W-1:0]         wb1_data,
  output logic                 rdy,
  output logic [W-1:0]         val
);

  logic [PR_ADDR_W-1:0] tag_q;
  logic [PR_ADDR_W-1:0] match_tag;
  logic                 hit0;
  logic                 hit1;
  logic                 wake;
  logic [W-1:0]         wake_val;

  // Compare against the incoming tag while loading so a same-cycle wakeup is not lost.
  always_comb begin
    match_tag = load ? in_tag : tag_q;
    hit0      = wb0_valid && (wb0_tag == match_tag);
    hit1      = wb1_valid && (wb1_tag == match_tag);
    wake      = hit0 || hit1;
    wake_val  = hit0 ? wb0_data : wb1_data;
  end

  // Ready flag: set at enqueue from dispatch or a wakeup, otherwise only by a wakeup while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy <= 1'b0;
    end else if (load) begin
      rdy <= in_rdy || wake;
    end else if (active && !rdy && wake) begin
      rdy <= 1'b1;
    end
  end

  // Tag and value storage needs no reset; it is only meaningful while rdy/valid say so.
  always_ff @(posedge clk) begin
    if (load) begin
      tag_q <= in_tag;
      val   <= in_rdy ? in_val : wake_val;
    end else if (active && !rdy && wake) begin
      val <= wake_val;
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: circular buffer of DEPTH entries, each with
// an offset and a data operand that wake up from two writeback ports. Only
// the head entry may issue, preserving memory ordering.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [4:0]           in_ROB_entry,
  input  logic [15:0]          in_base_val,
  input  logic [3:0]           in_imm,
  input  logic [PR_ADDR_W-1:0] in_dest_reg,
  input  logic [3:0]           in_dest_arch_regs,
  input  logic [PR_ADDR_W-1:0] in_offset_tag,
  input  logic                 in_offset_rdy,
  input  logic [7:0]           in_offset_val,
  input  logic [PR_ADDR_W-1:0] in_data_tag,
  input  logic                 in_data_rdy,
  input  logic [7:0]           in_data_val,
  input  logic                 wb0_valid,
  input  logic [PR_ADDR_W-1:0] wb0_tag,
  input  logic [7:0]           wb0_data,
  input  logic                 wb1_valid,
  input  logic [PR_ADDR_W-1:0] wb1_tag,
  input  logic [7:0]           wb1_data,
  input  logic                 flush,
  output logic [3:0]           opcode,
  output logic [4:0]           ROB_entry,
  output logic [15:0]          base_val,
  output logic [7:0]           offset,
  output logic [7:0]           data,
  output logic [3:0]           imm,
  output logic [PR_ADDR_W-1:0] dest_reg,
  output logic [3:0]           dest_arch_regs,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             empty;
  logic             full;
  logic             enq;
  logic             deq;

  iq_payload_t payload_q [DEPTH];
  logic        slot_valid [DEPTH];
  logic        off_rdy    [DEPTH];
  logic [7:0]  off_val    [DEPTH];
  logic        dat_rdy    [DEPTH];
  logic [7:0]  dat_val    [DEPTH];

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = (count == PTR_W'(DEPTH));

  // Handshake flags come purely from registered state plus flush gating.
  always_comb begin
    in_ready  = !full;
    out_valid = !empty && off_rdy[head_idx] && dat_rdy[head_idx] && !flush;
    enq       = in_valid && in_ready && !flush;
    deq       = out_valid && out_ready;
  end

  // Issue payload is read straight from the head slot.
  always_comb begin
    opcode         = payload_q[head_idx].opcode;
    ROB_entry      = payload_q[head_idx].rob_entry;
    base_val       = payload_q[head_idx].base_val;
    imm            = payload_q[head_idx].imm;
    dest_reg       = payload_q[head_idx].dest_reg;
    dest_arch_regs = payload_q[head_idx].dest_arch_regs;
    offset         = off_val[head_idx];
    data           = dat_val[head_idx];
  end

  // Pointer update: flush empties the queue and overrides any enqueue or issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
    end
  end

  // Static payload is captured at the tail slot on enqueue.
  always_ff @(posedge clk) begin
    if (enq) begin
      payload_q[tail_idx] <= '{
        opcode:         in_opcode,
        rob_entry:      in_ROB_entry,
        base_val:       in_base_val,
        imm:            in_imm,
        dest_reg:       in_dest_reg,
        dest_arch_regs: in_dest_arch_regs
      };
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [IDX_W-1:0] rel;
    logic             load;
    logic             active;

    assign rel           = IDX_W'(i) - head_idx;
    assign slot_valid[i] = ({1'b0, rel} < count);
    assign load          = enq && (tail_idx == IDX_W'(i));
    assign active        = slot_valid[i] && !flush;

    mem_iq_operand #(.W(8)) u_offset (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .active    (active),
      .in_tag    (in_offset_tag),
      .in_rdy    (in_offset_rdy),
      .in_val    (in_offset_val),
      .wb0_valid (wb0_valid),
      .wb0_tag   (wb0_tag),
      .wb0_data  (wb0_data),
      .wb1_valid (wb1_valid),
      .wb1_tag   (wb1_tag),
      .wb1_data  (wb1_data),
      .rdy       (off_rdy[i]),
      .val       (off_val[i])
    );

    mem_iq_operand #(.W(8)) u_data (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .active    (active),
      .in_tag    (in_data_tag),
      .in_rdy    (in_data_rdy),
      .in_val    (in_data_val),
      .wb0_valid (wb0_valid),
      .wb0_tag   (wb0_tag),
      .wb0_data  (wb0_data),
      .wb1_valid (wb1_valid),
      .wb1_tag   (wb1_tag),
      .wb1_data  (wb1_data),
      .rdy       (dat_rdy[i]),
      .val       (dat_val[i])
    );
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed testbench for mem_issue_queue: latency, wakeup, ordering,
// full/wrap behaviour, flush and reset.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_opcode;
  logic [4:0]           in_ROB_entry;
  logic [15:0]          in_base_val;
  logic [3:0]           in_imm;
  logic [PR_ADDR_W-1:0] in_dest_reg;
  logic [3:0]           in_dest_arch_regs;
  logic [PR_ADDR_W-1:0] in_offset_tag;
  logic                 in_offset_rdy;
  logic [7:0]           in_offset_val;
  logic [PR_ADDR_W-1:0] in_data_tag;
  logic                 in_data_rdy;
  logic [7:0]           in_data_val;
  logic                 wb0_valid;
  logic [PR_ADDR_W-1:0] wb0_tag;
  logic [7:0]           wb0_data;
  logic                 wb1_valid;
  logic [PR_ADDR_W-1:0] wb1_tag;
  logic [7:0]           wb1_data;
  logic                 flush;
  logic [3:0]           opcode;
  logic [4:0]           ROB_entry;
  logic [15:0]          base_val;
  logic [7:0]           offset;
  logic [7:0]           data;
  logic [3:0]           imm;
  logic [PR_ADDR_W-1:0] dest_reg;
  logic [3:0]           dest_arch_regs;
  logic                 out_valid;
  logic                 out_ready;

  int checks = 0;
  int passes = 0;

  mem_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_opcode         (in_opcode),
    .in_ROB_entry      (in_ROB_entry),
    .in_base_val       (in_base_val),
    .in_imm            (in_imm),
    .in_dest_reg       (in_dest_reg),
    .in_dest_arch_regs (in_dest_arch_regs),
    .in_offset_tag     (in_offset_tag),
    .in_offset_rdy     (in_offset_rdy),
    .in_offset_val     (in_offset_val),
    .in_data_tag       (in_data_tag),
    .in_data_rdy       (in_data_rdy),
    .in_data_val       (in_data_val),
    .wb0_valid         (wb0_valid),
    .wb0_tag           (wb0_tag),
    .wb0_data          (wb0_data),
    .wb1_valid         (wb1_valid),
    .wb1_tag           (wb1_tag),
    .wb1_data          (wb1_data),
    .flush             (flush),
    .opcode            (opcode),
    .ROB_entry         (ROB_entry),
    .base_val          (base_val),
    .offset            (offset),
    .data              (data),
    .imm               (imm),
    .dest_reg          (dest_reg),
    .dest_arch_regs    (dest_arch_regs),
    .out_valid         (out_valid),
    .out_ready         (out_ready)
  );

  // 10 ns clock; inputs change on the falling edge, outputs sampled 1 ns later.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Drive one enqueue request; imm/dest fields are derived from the ROB id.
  task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [4:0] rob,
                               input logic [15:0] base, input logic [PR_ADDR_W-1:0] otag,
                               input logic ordy, input logic [7:0] oval,
                               input logic [PR_ADDR_W-1:0] dtag, input logic drdy,
                               input logic [7:0] dval);
    in_valid          = valid;
    in_opcode         = op;
    in_ROB_entry      = rob;
    in_base_val       = base;
    in_imm            = rob[3:0];
    in_dest_reg       = PR_ADDR_W'(rob) + PR_ADDR_W'(1);
    in_dest_arch_regs = rob[3:0] ^ 4'hF;
    in_offset_tag     = otag;
    in_offset_rdy     = ordy;
    in_offset_val     = oval;
    in_data_tag       = dtag;
    in_data_rdy       = drdy;
    in_data_val       = dval;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic readyOp(input logic [4:0] rob, input logic [3:0] op);
    applyStimulus(1'b1, op, rob, 16'h6000 + 16'(rob), 6'd0, 1'b1, 8'h80 + 8'(rob),
                  6'd0, 1'b1, 8'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    wb0_tag = '0; wb0_data = '0; wb1_tag = '0; wb1_data = '0;
    applyStimulus(1'b0, OP_LB, 5'd0, 16'h0, 6'd0, 1'b0, 8'h0, 6'd0, 1'b0, 8'h0);
    idle();
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Ready load into an empty queue issues the next cycle.
    @(negedge clk);
    applyStimulus(1'b1, OP_LW, 5'd1, 16'h1200, 6'd0, 1'b1, 8'h05, 6'd0, 1'b1, 8'h00);
    #1 checkOutput("t1_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t1_out_valid_pre", 32'(out_valid), 32'd0);
    @(negedge clk);
    idle(); out_ready = 1'b1;
    #1 checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_base_val", 32'(base_val), 32'h1200);
    checkOutput("t1_offset", 32'(offset), 32'h05);
    checkOutput("t1_rob", 32'(ROB_entry), 32'd1);
    checkOutput("t1_opcode", 32'(opcode), 32'(OP_LW));
    checkOutput("t1_imm", 32'(imm), 32'd1);
    checkOutput("t1_dest_reg", 32'(dest_reg), 32'd2);
    checkOutput("t1_dest_arch", 32'(dest_arch_regs), 32'hE);
    @(negedge clk);
    out_ready = 1'b0;
    #1 checkOutput("t1_popped", 32'(out_valid), 32'd0);

    // Store waits on data tag 7, woken by port 1 three cycles later.
    @(negedge clk);
    applyStimulus(1'b1, OP_SW, 5'd2, 16'h2000, 6'd0, 1'b1, 8'h10, 6'd7, 1'b0, 8'h00);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      #1 checkOutput("t2_waiting", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    wb1_valid = 1'b1; wb1_tag = 6'd7; wb1_data = 8'hA5;
    #1 checkOutput("t2_wake_cycle", 32'(out_valid), 32'd0);
    @(negedge clk);
    idle(); out_ready = 1'b1;
    #1 checkOutput("t2_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_data", 32'(data), 32'hA5);
    checkOutput("t2_offset", 32'(offset), 32'h10);
    @(negedge clk);
    out_ready = 1'b0;
    #1 checkOutput("t2_popped", 32'(out_valid), 32'd0);

    // Head waits on tag 3; a ready younger entry must not overtake it.
    @(negedge clk);
    out_ready = 1'b1;
    applyStimulus(1'b1, OP_SB, 5'd3, 16'h3000, 6'd3, 1'b0, 8'h00, 6'd0, 1'b1, 8'h11);
    @(negedge clk);
    applyStimulus(1'b1, OP_LW, 5'd4, 16'h4000, 6'd12, 1'b1, 8'h22, 6'd0, 1'b1, 8'h00);
    #1 checkOutput("t3_blocked", 32'(out_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle();
      #1 checkOutput("t3_in_order", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    wb0_valid = 1'b1; wb0_tag = 6'd3; wb0_data = 8'h44;
    #1 checkOutput("t3_wake_cycle", 32'(out_valid), 32'd0);
    @(negedge clk);
    idle();
    #1 checkOutput("t3_first_valid", 32'(out_valid), 32'd1);
    checkOutput("t3_first_rob", 32'(ROB_entry), 32'd3);
    checkOutput("t3_first_offset", 32'(offset), 32'h44);
    @(negedge clk);
    #1 checkOutput("t3_second_valid", 32'(out_valid), 32'd1);
    checkOutput("t3_second_rob", 32'(ROB_entry), 32'd4);
    checkOutput("t3_second_offset", 32'(offset), 32'h22);
    @(negedge clk);
    out_ready = 1'b0;
    #1 checkOutput("t3_empty", 32'(out_valid), 32'd0);

    // Wakeup at enqueue on both ports: captured ready, port 0 value wins.
    @(negedge clk);
    applyStimulus(1'b1, OP_LB, 5'd5, 16'h5000, 6'd9, 1'b0, 8'h00, 6'd0, 1'b1, 8'h00);
    wb0_valid = 1'b1; wb0_tag = 6'd9; wb0_data = 8'h3C;
    wb1_valid = 1'b1; wb1_tag = 6'd9; wb1_data = 8'h77;
    @(negedge clk);
    idle(); out_ready = 1'b1;
    #1 checkOutput("t5_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t5_offset", 32'(offset), 32'h3C);
    @(negedge clk);
    out_ready = 1'b0;
    #1 checkOutput("t5_popped", 32'(out_valid), 32'd0);

    // Fill to DEPTH (pointers wrap), then stream with simultaneous enqueue and issue.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      readyOp(5'(i), OP_LW);
      #1 checkOutput("t4_fill_in_ready", 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    idle();
    #1 checkOutput("t4_full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("t4_full_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t4_full_rob", 32'(ROB_entry), 32'd0);
    @(negedge clk);
    readyOp(5'd8, OP_LW); out_ready = 1'b1;
    #1 checkOutput("t4_no_passthru", 32'(in_ready), 32'd0);
    checkOutput("t4_pop_rob", 32'(ROB_entry), 32'd0);
    for (int k = 1; k < DEPTH; k++) begin
      @(negedge clk);
      readyOp(5'(7 + k), OP_LW);
      #1 checkOutput("t4_stream_in_ready", 32'(in_ready), 32'd1);
      checkOutput("t4_stream_valid", 32'(out_valid), 32'd1);
      checkOutput("t4_stream_rob", 32'(ROB_entry), 32'(k));
    end
    for (int k = DEPTH; k < 2 * DEPTH - 1; k++) begin
      @(negedge clk);
      idle();
      #1 checkOutput("t4_drain_valid", 32'(out_valid), 32'd1);
      checkOutput("t4_drain_rob", 32'(ROB_entry), 32'(k));
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1 checkOutput("t4_drained", 32'(out_valid), 32'd0);

    // Flush with five entries queued while enqueue, issue and wakeup are all asserted.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      readyOp(5'(16 + i), OP_SW);
    end
    @(negedge clk);
    readyOp(5'd31, OP_LW);
    out_ready = 1'b1; flush = 1'b1;
    wb0_valid = 1'b1; wb0_tag = 6'd1; wb0_data = 8'hEE;
    #1 checkOutput("t6_flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_flush_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    idle();
    #1 checkOutput("t6_after_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_after_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    readyOp(5'd20, OP_LW);
    @(negedge clk);
    idle();
    #1 checkOutput("t6_fresh_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_fresh_rob", 32'(ROB_entry), 32'd20);
    @(negedge clk);
    out_ready = 1'b0;
    #1 checkOutput("t6_fresh_popped", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a cycle drops queued work.
    @(negedge clk);
    readyOp(5'd21, OP_LW);
    @(negedge clk);
    idle();
    #1 checkOutput("t7_pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1 checkOutput("t7_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t7_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 checkOutput("t7_post_rst_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
